// File: rtl/core_pkg.sv
// Core-wide widths and writeback request types shared by the PRF writeback path.
package core_pkg;

   localparam int XLEN    = 32;
   localparam int PREGS   = 64;
   localparam int TAG_W   = $clog2(PREGS);
   localparam int WB_NREQ = 4;

   typedef logic [TAG_W-1:0] preg_tag_t;

   typedef struct packed {
      preg_tag_t       tag;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/prf_wb_arbiter_rr_pick.sv
// Find-first-set over (req & ~excl) starting at ptr and wrapping; purely combinational.
// No latency, no backpressure: found=0 when nothing eligible.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   input  logic [N-1:0]         excl,
   output logic                 found,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   logic [N-1:0] eligible;
   int           pos;

   assign eligible = req & ~excl;

   // Scan from the far end back toward ptr so the nearest eligible slot wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         if (eligible[pos]) begin
            found = 1'b1;
            idx   = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Two-port PRF writeback arbiter: combinational grants (req_ready), registered PRF writes 1 cycle later.
// Ungranted requesters are backpressured by holding req_ready low; they keep valid/tag/data stable.
module prf_wb_arbiter #(
   parameter int XLEN  = core_pkg::XLEN,
   parameter int PREGS = core_pkg::PREGS,
   parameter int N_REQ = core_pkg::WB_NREQ,
   parameter int PRIO0 = 1,
   parameter int CNT_W = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [N_REQ-1:0]                 req_valid,
   input  logic [N_REQ*$clog2(PREGS)-1:0]   req_tag,
   input  logic [N_REQ*XLEN-1:0]            req_data,
   output logic [N_REQ-1:0]                 req_ready,
   output logic                             wen0,
   output logic                             wen1,
   output logic [$clog2(PREGS)-1:0]         wtag0,
   output logic [$clog2(PREGS)-1:0]         wtag1,
   output logic [XLEN-1:0]                  wdata0,
   output logic [XLEN-1:0]                  wdata1,
   output logic                             err_dup_tag,
   output logic [CNT_W-1:0]                 contend_cnt
);

   localparam int TW = $clog2(PREGS);
   localparam int IW = $clog2(N_REQ);

   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    rr_ptr_nxt;

   logic             prio_hit;
   logic             a_rr_found;
   logic [IW-1:0]    a_rr_idx;
   logic             a_any;
   logic [IW-1:0]    a_idx;
   logic [N_REQ-1:0] a_oh;

   logic             b_found;
   logic [IW-1:0]    b_idx;
   logic [N_REQ-1:0] b_oh;

   logic [TW-1:0]    tag_a;
   logic [TW-1:0]    tag_b;
   logic [XLEN-1:0]  data_a;
   logic [XLEN-1:0]  data_b;

   logic             contend;
   int               nvalid;

   assign prio_hit = (PRIO0 != 0) && req_valid[0];

   rr_pick #(.N(N_REQ)) u_pick_a (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .excl  ({N_REQ{1'b0}}),
      .found (a_rr_found),
      .idx   (a_rr_idx)
   );

   assign a_any = prio_hit || a_rr_found;
   assign a_idx = prio_hit ? '0 : a_rr_idx;

   always_comb begin
      a_oh = '0;
      if (a_any) a_oh[a_idx] = 1'b1;
   end

   // Port 1 is the same round-robin scan with port 0's winner masked out.
   rr_pick #(.N(N_REQ)) u_pick_b (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .excl  (a_oh),
      .found (b_found),
      .idx   (b_idx)
   );

   always_comb begin
      b_oh = '0;
      if (b_found) b_oh[b_idx] = 1'b1;
   end

   assign req_ready = a_oh | b_oh;

   assign tag_a  = req_tag[a_idx*TW +: TW];
   assign tag_b  = req_tag[b_idx*TW +: TW];
   assign data_a = req_data[a_idx*XLEN +: XLEN];
   assign data_b = req_data[b_idx*XLEN +: XLEN];

   // Port 1's winner is always later in RR order than an RR port-0 winner; a priority win of
   // requester 0 never moves the pointer.
   always_comb begin
      rr_ptr_nxt = rr_ptr;
      if (b_found) begin
         rr_ptr_nxt = (b_idx == IW'(N_REQ - 1)) ? '0 : b_idx + 1'b1;
      end else if (a_rr_found && !prio_hit) begin
         rr_ptr_nxt = (a_idx == IW'(N_REQ - 1)) ? '0 : a_idx + 1'b1;
      end
   end

   always_comb begin
      nvalid = 0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_valid[i]) nvalid = nvalid + 1;
      end
   end

   assign contend = (nvalid > 2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr      <= '0;
         wen0        <= 1'b0;
         wen1        <= 1'b0;
         wtag0       <= '0;
         wtag1       <= '0;
         wdata0      <= '0;
         wdata1      <= '0;
         err_dup_tag <= 1'b0;
         contend_cnt <= '0;
      end else begin
         rr_ptr <= rr_ptr_nxt;
         wen0   <= a_any;
         wen1   <= b_found;
         if (a_any) begin
            wtag0  <= tag_a;
            wdata0 <= data_a;
         end
         if (b_found) begin
            wtag1  <= tag_b;
            wdata1 <= data_b;
         end
         if (a_any && b_found && (tag_a == tag_b)) err_dup_tag <= 1'b1;
         if (contend && (contend_cnt != {CNT_W{1'b1}})) contend_cnt <= contend_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Drives a PRIO0=1 instance and a PRIO0=0/CNT_W=4 instance against a queue-free reference model.
module tb_prf_wb_arbiter;

   localparam int N  = 4;
   localparam int TW = 6;
   localparam int XW = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]  sv [2];
   logic [TW-1:0] st [2][N];
   logic [XW-1:0] sd [2][N];

   logic [N*TW-1:0] tag_a, tag_b;
   logic [N*XW-1:0] dat_a, dat_b;
   assign tag_a = {st[0][3], st[0][2], st[0][1], st[0][0]};
   assign tag_b = {st[1][3], st[1][2], st[1][1], st[1][0]};
   assign dat_a = {sd[0][3], sd[0][2], sd[0][1], sd[0][0]};
   assign dat_b = {sd[1][3], sd[1][2], sd[1][1], sd[1][0]};

   logic [N-1:0]  rdy_a, rdy_b;
   logic          wen0_a, wen1_a, wen0_b, wen1_b, err_a, err_b;
   logic [TW-1:0] wtag0_a, wtag1_a, wtag0_b, wtag1_b;
   logic [XW-1:0] wdata0_a, wdata1_a, wdata0_b, wdata1_b;
   logic [15:0]   cnt_a;
   logic [3:0]    cnt_b;

   prf_wb_arbiter #(.XLEN(XW), .PREGS(64), .N_REQ(N), .PRIO0(1), .CNT_W(16)) u_dut_a (
      .clk(clk), .reset(reset), .req_valid(sv[0]), .req_tag(tag_a), .req_data(dat_a),
      .req_ready(rdy_a), .wen0(wen0_a), .wen1(wen1_a), .wtag0(wtag0_a), .wtag1(wtag1_a),
      .wdata0(wdata0_a), .wdata1(wdata1_a), .err_dup_tag(err_a), .contend_cnt(cnt_a)
   );

   prf_wb_arbiter #(.XLEN(XW), .PREGS(64), .N_REQ(N), .PRIO0(0), .CNT_W(4)) u_dut_b (
      .clk(clk), .reset(reset), .req_valid(sv[1]), .req_tag(tag_b), .req_data(dat_b),
      .req_ready(rdy_b), .wen0(wen0_b), .wen1(wen1_b), .wtag0(wtag0_b), .wtag1(wtag1_b),
      .wdata0(wdata0_b), .wdata1(wdata1_b), .err_dup_tag(err_b), .contend_cnt(cnt_b)
   );

   logic [N-1:0]  o_rdy [2];
   logic          o_wen0 [2], o_wen1 [2], o_err [2];
   logic [TW-1:0] o_tag0 [2], o_tag1 [2];
   logic [XW-1:0] o_dat0 [2], o_dat1 [2];
   logic [15:0]   o_cnt [2];
   assign o_rdy[0]  = rdy_a;    assign o_rdy[1]  = rdy_b;
   assign o_wen0[0] = wen0_a;   assign o_wen0[1] = wen0_b;
   assign o_wen1[0] = wen1_a;   assign o_wen1[1] = wen1_b;
   assign o_err[0]  = err_a;    assign o_err[1]  = err_b;
   assign o_tag0[0] = wtag0_a;  assign o_tag0[1] = wtag0_b;
   assign o_tag1[0] = wtag1_a;  assign o_tag1[1] = wtag1_b;
   assign o_dat0[0] = wdata0_a; assign o_dat0[1] = wdata0_b;
   assign o_dat1[0] = wdata1_a; assign o_dat1[1] = wdata1_b;
   assign o_cnt[0]  = cnt_a;    assign o_cnt[1]  = {12'd0, cnt_b};

   // Reference model state
   int            mptr [2];
   int            ga [2], gb [2];
   logic          mwen0 [2], mwen1 [2], merr [2];
   logic [TW-1:0] mtag0 [2], mtag1 [2];
   logic [XW-1:0] mdat0 [2], mdat1 [2];
   int            mcnt [2];
   int            cmax [2] = '{65535, 15};
   bit            prio [2] = '{1'b1, 1'b0};

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mptr[d] = 0; ga[d] = -1; gb[d] = -1;
         mwen0[d] = 0; mwen1[d] = 0; merr[d] = 0; mcnt[d] = 0;
         mtag0[d] = '0; mtag1[d] = '0; mdat0[d] = '0; mdat1[d] = '0;
      end
   endtask

   // Walk the requesters in order starting at the pointer; first two valid ones win,
   // except that requester 0 jumps the queue for port 0 when priority is enabled.
   task automatic pick(input int d);
      int a, b, i;
      a = -1; b = -1;
      if (prio[d] && sv[d][0]) a = 0;
      for (int k = 0; k < N; k++) begin
         i = (mptr[d] + k) % N;
         if (sv[d][i]) begin
            if (a < 0) a = i;
            else if (b < 0 && i != a) b = i;
         end
      end
      ga[d] = a; gb[d] = b;
      if (b >= 0) mptr[d] = (b + 1) % N;
      else if (a >= 0 && !(prio[d] && a == 0)) mptr[d] = (a + 1) % N;
   endtask

   task automatic cycle();
      logic [N-1:0] er;
      int nv;
      #1;
      for (int d = 0; d < 2; d++) begin
         pick(d);
         er = '0;
         if (ga[d] >= 0) er[ga[d]] = 1'b1;
         if (gb[d] >= 0) er[gb[d]] = 1'b1;
         check($sformatf("ready[%0d]", d), o_rdy[d], er);
         nv = 0;
         for (int i = 0; i < N; i++) nv += sv[d][i];
         if (nv > 2 && mcnt[d] < cmax[d]) mcnt[d]++;
         if (ga[d] >= 0 && gb[d] >= 0 && st[d][ga[d]] == st[d][gb[d]]) merr[d] = 1'b1;
         mwen0[d] = (ga[d] >= 0);
         mwen1[d] = (gb[d] >= 0);
         if (ga[d] >= 0) begin mtag0[d] = st[d][ga[d]]; mdat0[d] = sd[d][ga[d]]; end
         if (gb[d] >= 0) begin mtag1[d] = st[d][gb[d]]; mdat1[d] = sd[d][gb[d]]; end
      end
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("wen0[%0d]", d), o_wen0[d], mwen0[d]);
         check($sformatf("wen1[%0d]", d), o_wen1[d], mwen1[d]);
         check($sformatf("wtag0[%0d]", d), o_tag0[d], mtag0[d]);
         check($sformatf("wtag1[%0d]", d), o_tag1[d], mtag1[d]);
         check($sformatf("wdata0[%0d]", d), o_dat0[d], mdat0[d]);
         check($sformatf("wdata1[%0d]", d), o_dat1[d], mdat1[d]);
         check($sformatf("err[%0d]", d), o_err[d], merr[d]);
         check($sformatf("cnt[%0d]", d), o_cnt[d], mcnt[d]);
      end
   endtask

   // Granted requesters may retire or re-present; ungranted ones hold everything stable.
   task automatic next_stim();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < N; i++) begin
            if (sv[d][i] && (ga[d] == i || gb[d] == i)) begin
               sv[d][i] = 1'($urandom_range(0, 1));
               st[d][i] = TW'($urandom_range(0, 63));
               sd[d][i] = $urandom;
            end else if (!sv[d][i] && $urandom_range(0, 1) == 1) begin
               sv[d][i] = 1'b1;
               st[d][i] = TW'($urandom_range(0, 63));
               sd[d][i] = $urandom;
            end
         end
      end
   endtask

   // Entered and left at a falling edge; reset is asserted mid-cycle to exercise the async path.
   task automatic do_reset();
      for (int d = 0; d < 2; d++) sv[d] = '0;
      #2 reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_wen0[%0d]", d), o_wen0[d], 0);
         check($sformatf("rst_wen1[%0d]", d), o_wen1[d], 0);
         check($sformatf("rst_tags[%0d]", d), {o_tag0[d], o_tag1[d]}, 0);
         check($sformatf("rst_data[%0d]", d), {o_dat0[d], o_dat1[d]}, 0);
         check($sformatf("rst_err[%0d]", d), o_err[d], 0);
         check($sformatf("rst_cnt[%0d]", d), o_cnt[d], 0);
         check($sformatf("rst_ready[%0d]", d), o_rdy[d], 0);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic all_valid_distinct();
      for (int d = 0; d < 2; d++) begin
         sv[d] = '1;
         for (int i = 0; i < N; i++) begin
            st[d][i] = TW'(i + 1);
            sd[d][i] = $urandom;
         end
      end
   endtask

   int port1_seq [4] = '{1, 2, 3, 1};
   int pair_seq  [4] = '{0, 2, 0, 2};
   int waited;

   initial begin
      for (int d = 0; d < 2; d++) begin
         sv[d] = '0;
         for (int i = 0; i < N; i++) begin st[d][i] = '0; sd[d][i] = '0; end
      end
      model_reset();
      @(negedge clk);
      do_reset();

      // Single request on requester 2
      sv[0] = 4'b0100; st[0][2] = 6'd7; sd[0][2] = 32'hDEAD;
      #1 check("single_ready", o_rdy[0], 4'b0100);
      cycle();
      check("single_wen0", o_wen0[0], 1);
      check("single_wtag0", o_tag0[0], 7);
      check("single_wdata0", o_dat0[0], 32'hDEAD);
      check("single_wen1", o_wen1[0], 0);
      sv[0] = '0;
      cycle();

      // All valid from rr_ptr=0 on both flavours
      do_reset();
      all_valid_distinct();
      for (int c = 0; c < 4; c++) begin
         cycle();
         check("prio_port0", o_tag0[0], 1);
         check("prio_port1", o_tag1[0], port1_seq[c] + 1);
         check("rr_port0", o_tag0[1], pair_seq[c] + 1);
         check("rr_port1", o_tag1[1], pair_seq[c] + 2);
         check("rr_contend", o_cnt[1], c + 1);
      end

      // Duplicate tags on requesters 0 and 2
      do_reset();
      for (int d = 0; d < 2; d++) begin
         sv[d] = 4'b0101; st[d][0] = 6'd12; st[d][2] = 6'd12;
         sd[d][0] = $urandom; sd[d][2] = $urandom;
      end
      cycle();
      for (int d = 0; d < 2; d++) begin
         check("dup_wens", {o_wen0[d], o_wen1[d]}, 2'b11);
         check("dup_tags", {o_tag0[d], o_tag1[d]}, {6'd12, 6'd12});
         check("dup_err", o_err[d], 1);
         sv[d] = '0;
      end
      cycle();
      cycle();
      check("dup_err_sticky", o_err[1], 1);

      // Saturation of the 4-bit contention counter
      do_reset();
      sv[1] = 4'b0111;
      for (int i = 0; i < 3; i++) begin st[1][i] = TW'(i + 20); sd[1][i] = $urandom; end
      for (int c = 0; c < 18; c++) cycle();
      check("cnt_saturated", o_cnt[1], 4'hF);

      // Random traffic
      do_reset();
      for (int c = 0; c < 400; c++) begin
         next_stim();
         cycle();
      end

      // Reset while a write is in flight, then confirm the pointer restarted at 0
      waited = 0;
      while (!o_wen0[0] && waited < 50) begin
         next_stim();
         cycle();
         waited++;
      end
      check("pre_reset_wen0", o_wen0[0], 1);
      do_reset();
      all_valid_distinct();
      cycle();
      check("post_reset_port0", o_tag0[1], 1);
      check("post_reset_port1", o_tag1[1], 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
